shift_add_multiplier: RTL and testbench
=======================================

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 The block SHALL take parameter N, default 8, as the operand width in bits; legal values are 2 to 32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: an operand pair is presented.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept an operand pair.
REQ-006 The block SHALL have port in_a, input, N bits: unsigned multiplicand.
REQ-007 The block SHALL have port in_b, input, N bits: unsigned multiplier.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_product holds a finished result.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-010 The block SHALL have port out_product, output, 2N bits: unsigned product in_a*in_b.

Function
REQ-011 The block SHALL implement a 3-state FSM: IDLE, CALC, DONE.
REQ-012 In IDLE the block SHALL drive in_ready=1, out_valid=0; in every other state in_ready SHALL be 0.
REQ-013 An input handshake SHALL occur at a rising edge where in_valid=1 and in_ready=1; at that edge: latch in_a to the multiplicand register, in_b to the low half of a 2N-bit accumulator, clear the high half, clear the iteration counter, go to CALC.
REQ-014 in_valid while in_ready=0 SHALL be ignored; no operand latch, no state change.
REQ-015 Each CALC cycle SHALL form {carry,sum} = acc_hi + (acc[0] ? multiplicand : 0) through an N-bit adder with carry-in 0.
REQ-016 At the end of each CALC cycle: acc <= {carry, sum, acc[N-1:1]} (right shift by one, carry into MSB); counter increments.
REQ-017 After exactly N CALC cycles the FSM SHALL enter DONE; out_valid asserts on the Nth rising edge after the input-handshake edge.
REQ-018 In DONE the block SHALL drive out_valid=1 and out_product=acc; both SHALL stay stable while out_ready=0, for any duration.
REQ-019 An output handshake at a rising edge with out_valid=1 and out_ready=1 SHALL return the FSM to IDLE; the next input is accepted no earlier than the following edge (min issue interval N+2 cycles).
REQ-020 out_product SHALL hold its last value outside DONE; it is meaningful only when out_valid=1.
REQ-021 The result SHALL be exact for all operands: 2N bits, no overflow, no truncation; operand 0 or 1 SHALL take the full N cycles (no early exit).
REQ-022 The iteration counter SHALL be ceil(log2(N+1)) bits wide and SHALL never wrap.

Reset
REQ-023 When rst_n=0 the block SHALL immediately set the FSM to IDLE and set in_ready=1, out_valid=0, out_product=0, accumulator=0, multiplicand=0, counter=0.
REQ-024 Reset asserted mid-CALC or in DONE SHALL discard the operation; no out_valid SHALL follow for it.
REQ-025 After rst_n deasserts, the first rising edge SHALL be able to accept an input handshake.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding (IDLE=2'b00, CALC=2'b01, DONE=2'b10) and the default N.
REQ-027 The per-cycle addition SHALL use one instance of the existing multi_bit_full_adder (parameter N, carry-in tied 0); no other sub-modules.

Verification
REQ-028 Verify N=8: reset, then in_a=13, in_b=11 -> out_valid exactly 8 edges after acceptance, out_product=143 (0x008F).
REQ-029 Verify N=8: in_a=0xFF, in_b=0xFF -> out_product=0xFE01; then in_a=0x00, in_b=0x55 -> 0x0000 with the same 8-cycle latency.
REQ-030 Verify backpressure: out_ready held 0 for 5 cycles after out_valid -> out_product and out_valid unchanged; in_ready=0 throughout; the handshake returns to IDLE next edge.
REQ-031 Verify busy rejection: in_valid=1 with in_a=3, in_b=3 during CALC of 7*5 -> result 35; the 3*3 pair is not consumed.
REQ-032 Verify reset mid-operation: rst_n=0 on cycle 4 of 200*100 -> outputs zero immediately, no out_valid; the next 2*2 gives 4.
REQ-033 Verify randomized 1000 pairs with random out_ready against a reference model a*b; also run with N=16 for 0xFFFF*0xFFFF=0xFFFE0001.

Source files
------------

// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-add multiplier: FSM encoding and default operand width.
package shift_add_multiplier_pkg;

  localparam int unsigned DEFAULT_N = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/multi_bit_full_adder.sv
// N-bit adder with carry-in and carry-out, used once per iteration of the multiplier.
module multi_bit_full_adder #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] total;

  assign total = {1'b0, a} + {1'b0, b} + (N+1)'(cin);
  assign sum   = total[N-1:0];
  assign cout  = total[N];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier: one add-and-shift step per cycle, N cycles per product,
// valid/ready handshakes on both the operand and the result side.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_a,
  input  logic [N-1:0]   in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_product
);

  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned PW = 2 * N;

  if (N < 2 || N > 32) begin : g_bad_n
    $error("shift_add_multiplier: N must be in 2..32");
  end

  state_t        state;
  state_t        state_next;
  logic [N-1:0]  mcand;
  logic [N-1:0]  mcand_next;
  logic [PW-1:0] acc;
  logic [PW-1:0] acc_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [PW-1:0] product_next;
  logic          in_ready_next;
  logic          out_valid_next;

  logic [N-1:0]  addend;
  logic [N-1:0]  sum;
  logic          carry;
  logic          last_iter;
  logic [PW-1:0] acc_shifted;

  // Partial-product add: high half of the accumulator plus the multiplicand when the current multiplier bit is set.
  assign addend = acc[0] ? mcand : '0;

  multi_bit_full_adder #(.N(N)) u_adder (
    .a    (acc[PW-1:N]),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (carry)
  );

  assign acc_shifted = {carry, sum, acc[N-1:1]};
  assign last_iter   = (cnt == CW'(N - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = CALC;
      CALC:    if (last_iter) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    mcand_next     = mcand;
    acc_next       = acc;
    cnt_next       = cnt;
    product_next   = out_product;
    in_ready_next  = (state_next == IDLE);
    out_valid_next = (state_next == DONE);
    case (state)
      IDLE: begin
        if (in_valid) begin
          mcand_next = in_a;
          acc_next   = {{N{1'b0}}, in_b};
          cnt_next   = '0;
        end
      end
      CALC: begin
        acc_next = acc_shifted;
        cnt_next = cnt + CW'(1);
        if (last_iter) product_next = acc_shifted;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand       <= '0;
      acc         <= '0;
      cnt         <= '0;
      out_product <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
    end else begin
      mcand       <= mcand_next;
      acc         <= acc_next;
      cnt         <= cnt_next;
      out_product <= product_next;
      in_ready    <= in_ready_next;
      out_valid   <= out_valid_next;
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed-vector and randomized checks of shift_add_multiplier at N=8, plus one N=16 corner product.
module tb_shift_add_multiplier;

  localparam int unsigned N   = 8;
  localparam int unsigned N16 = 16;

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] p;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_a;
  logic [N-1:0]   in_b;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] out_product;

  logic             in_valid16;
  logic             in_ready16;
  logic [N16-1:0]   in_a16;
  logic [N16-1:0]   in_b16;
  logic             out_valid16;
  logic             out_ready16;
  logic [2*N16-1:0] out_product16;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  shift_add_multiplier #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product)
  );

  shift_add_multiplier #(.N(N16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid16), .in_ready(in_ready16), .in_a(in_a16), .in_b(in_b16),
    .out_valid(out_valid16), .out_ready(out_ready16), .out_product(out_product16)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Present an operand pair and complete the input handshake; returns #1 after the accepting edge.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic collect();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("post_collect_idle", {62'd0, in_ready, out_valid}, 64'b10);
  endtask

  task automatic run_rand(input logic [N-1:0] a, input logic [N-1:0] b);
    int cyc = 0;
    bit done = 1'b0;
    logic [2*N-1:0] exp;
    exp = (2*N)'(a) * (2*N)'(b);
    issue(a, b);
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        out_ready = 1'($urandom_range(0, 1));
        if (out_ready) begin
          check("rand_product", 64'(out_product), 64'(exp));
          done = 1'b1;
        end
      end
    end
    if (!done) check("rand_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    vec_t vecs[8];
    int lat;
    bit seen;

    vecs[0] = '{a: 8'd13,   b: 8'd11,   p: 16'h008F};
    vecs[1] = '{a: 8'hFF,   b: 8'hFF,   p: 16'hFE01};
    vecs[2] = '{a: 8'h00,   b: 8'h55,   p: 16'h0000};
    vecs[3] = '{a: 8'h01,   b: 8'h01,   p: 16'h0001};
    vecs[4] = '{a: 8'h80,   b: 8'h02,   p: 16'h0100};
    vecs[5] = '{a: 8'hFF,   b: 8'h01,   p: 16'h00FF};
    vecs[6] = '{a: 8'hAA,   b: 8'h55,   p: 16'h3872};
    vecs[7] = '{a: 8'h10,   b: 8'h10,   p: 16'h0100};

    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    in_valid16 = 1'b0; in_a16 = '0; in_b16 = '0; out_ready16 = 1'b0;
    #12;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_product", 64'(out_product), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven products with latency check
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].a, vecs[i].b);
      wait_result(lat);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(N));
      check($sformatf("vec%0d_product", i), 64'(out_product), 64'(vecs[i].p));
      collect();
    end

    // Backpressure: result held while out_ready stays low
    issue(8'h12, 8'h34);
    wait_result(lat);
    check("bp_latency", 64'(lat), 64'(N));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_hold%0d", i), {47'd0, out_valid, in_ready, out_product}, {47'd0, 1'b1, 1'b0, 16'h03A8});
    end
    collect();

    // Busy rejection: second pair offered during CALC must be ignored
    issue(8'd7, 8'd5);
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'd3; in_b = 8'd3;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("busy_product", 64'(out_product), 64'd35);
    collect();
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (out_valid || !in_ready) seen = 1'b1;
    end
    check("busy_not_consumed", 64'(seen), 64'd0);

    // Reset during the fourth CALC cycle
    issue(8'd200, 8'd100);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", {61'd0, in_ready, out_valid, 1'b0}, {61'd0, 1'b1, 1'b0, 1'b0});
    check("midrst_product", 64'(out_product), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (N + 4) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_valid", 64'(seen), 64'd0);
    issue(8'd2, 8'd2);
    wait_result(lat);
    check("after_rst_latency", 64'(lat), 64'(N));
    check("after_rst_product", 64'(out_product), 64'd4);
    collect();

    // Randomized pairs with random consumer stalls
    for (int i = 0; i < 1000; i++) begin
      run_rand(N'($urandom), N'($urandom));
    end

    // N=16 full-scale product
    @(negedge clk);
    in_valid16 = 1'b1; in_a16 = 16'hFFFF; in_b16 = 16'hFFFF;
    @(posedge clk);
    #1;
    in_valid16 = 1'b0;
    lat = 0;
    while (!out_valid16 && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("n16_latency", 64'(lat), 64'(N16));
    check("n16_product", 64'(out_product16), 64'hFFFE0001);
    @(negedge clk);
    out_ready16 = 1'b1;
    @(posedge clk);
    #1;
    out_ready16 = 1'b0;
    check("n16_idle", 64'(in_ready16), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
